// File: rtl/cia_serialport_pkg.sv
// Shared types and widths for the CIA serial data port (SDR).
//   SDR_DATA_W : width of the SDR byte
//   SP_BITS_W  : width of the per-transfer bit counter (counts 0..8)
//   sp_state_e : output shifter state (idle / shifting)
package cia_serialport_pkg;

  localparam int unsigned SDR_DATA_W = 8;
  localparam int unsigned SP_BITS_W  = 4;

  typedef enum logic {
    SP_IDLE  = 1'b0,
    SP_SHIFT = 1'b1
  } sp_state_e;

endpackage

// File: rtl/cia_serialport_if.sv
// CPU bus view of the SDR register.
//   wr       : bus write strobe
//   sdr      : SDR register select
//   data_in  : bus write data
//   data_out : bus read data (0x00 unless SDR is being read)
interface cia_serialport_if;
  import cia_serialport_pkg::*;

  logic                  wr;
  logic                  sdr;
  logic [SDR_DATA_W-1:0] data_in;
  logic [SDR_DATA_W-1:0] data_out;

  modport master (output wr, output sdr, output data_in, input  data_out);
  modport slave  (input  wr, input  sdr, input  data_in, output data_out);

endinterface

// File: rtl/cia_serialport.sv
// 8520 CIA serial data port. Output mode shifts the SDR byte out MSB first,
// toggling CNT on every timer A underflow; input mode shifts SP in on CNT
// rising edges. Raises a one-cycle interrupt after every completed byte.
//   clk, reset  : system clock, synchronous active-high reset
//   i_clk7_en   : clock enable, all state updates gated by it
//   bus         : SDR register bus access (slave)
//   i_tmra_ovf  : timer A underflow strobe
//   i_spmode    : 1 = output, 0 = input
//   i_cnt_in    : CNT pin level
//   i_sp_in     : SP pin level
//   o_cnt_out   : CNT drive (output mode)
//   o_sp_out    : SP drive (output mode)
//   o_irq       : serial-port interrupt pulse
module cia_serialport
  import cia_serialport_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clk7_en,
  cia_serialport_if.slave bus,
  input  logic            i_tmra_ovf,
  input  logic            i_spmode,
  input  logic            i_cnt_in,
  input  logic            i_sp_in,
  output logic            o_cnt_out,
  output logic            o_sp_out,
  output logic            o_irq
);

  localparam int unsigned          BITS_PER_XFER = 8;
  localparam logic [SP_BITS_W-1:0] BITS_LAST     = SP_BITS_W'(BITS_PER_XFER - 1);

  sp_state_e             r_state;
  logic [SDR_DATA_W-1:0] r_sdr_buf;
  logic [SDR_DATA_W-1:0] r_shreg;
  logic [SP_BITS_W-1:0]  r_bits;
  logic                  r_pending;
  logic                  r_cnt_out;
  logic                  r_sp_out;
  logic                  r_irq;
  logic                  r_cnt_d;
  logic                  r_spmode_d;

  logic                  w_bus_wr;
  logic                  w_mode_chg;
  logic                  w_cnt_rise;
  logic [SDR_DATA_W-1:0] w_in_byte;

  assign w_bus_wr   = bus.sdr & bus.wr;
  assign w_mode_chg = i_spmode != r_spmode_d;
  assign w_cnt_rise = i_cnt_in & ~r_cnt_d;
  assign w_in_byte  = {r_shreg[SDR_DATA_W-2:0], i_sp_in};

  // Register read path is combinational from the buffer.
  assign bus.data_out = (bus.sdr & ~bus.wr) ? r_sdr_buf : '0;

  assign o_cnt_out = r_cnt_out;
  assign o_sp_out  = r_sp_out;
  assign o_irq     = r_irq;

  // Shifter, bit counter, buffer and interrupt state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= SP_IDLE;
      r_sdr_buf  <= '0;
      r_shreg    <= '0;
      r_bits     <= '0;
      r_pending  <= 1'b0;
      r_cnt_out  <= 1'b1;
      r_sp_out   <= 1'b1;
      r_irq      <= 1'b0;
      r_cnt_d    <= 1'b1;
      // Track the mode during reset so leaving reset is not seen as a switch.
      r_spmode_d <= i_spmode;
    end else if (i_clk7_en) begin
      r_irq      <= 1'b0;
      r_cnt_d    <= i_cnt_in;
      r_spmode_d <= i_spmode;

      if (w_bus_wr) begin
        r_sdr_buf <= bus.data_in;
        if (i_spmode) r_pending <= 1'b1;
      end

      if (w_mode_chg) begin
        // Abort any transfer; the buffer keeps its contents.
        r_state   <= SP_IDLE;
        r_bits    <= '0;
        r_pending <= 1'b0;
        r_cnt_out <= 1'b1;
      end else if (i_spmode) begin
        case (r_state)
          SP_IDLE: begin
            if (i_tmra_ovf && r_pending) begin
              // Loads the pre-write buffer; a colliding write stays pending.
              r_shreg   <= r_sdr_buf;
              r_sp_out  <= r_sdr_buf[SDR_DATA_W-1];
              r_cnt_out <= 1'b0;
              r_bits    <= '0;
              r_pending <= w_bus_wr;
              r_state   <= SP_SHIFT;
            end
          end
          SP_SHIFT: begin
            if (i_tmra_ovf) begin
              if (!r_cnt_out) begin
                r_cnt_out <= 1'b1;
                r_bits    <= r_bits + SP_BITS_W'(1);
                // Leave SHIFT on the 8th rise so a pending byte loads on the
                // very next underflow with no extra gap.
                if (r_bits == BITS_LAST) begin
                  r_irq   <= 1'b1;
                  r_state <= SP_IDLE;
                end
              end else begin
                r_cnt_out <= 1'b0;
                r_shreg   <= r_shreg << 1;
                r_sp_out  <= r_shreg[SDR_DATA_W-2];
              end
            end
          end
          default: r_state <= SP_IDLE;
        endcase
      end else begin
        r_state   <= SP_IDLE;
        r_cnt_out <= 1'b1;
        if (w_cnt_rise) begin
          r_shreg <= w_in_byte;
          if (r_bits == BITS_LAST) begin
            // Completion overrides a same-cycle bus write.
            r_sdr_buf <= w_in_byte;
            r_bits    <= '0;
            r_irq     <= 1'b1;
          end else begin
            r_bits <= r_bits + SP_BITS_W'(1);
          end
        end
      end
    end
  end

endmodule
